sync_up_counter: RTL
====================

# sync_up_counter

Synchronous, parameterized modulo-N up counter, the counting-up counterpart to the team's ripple down counters. Every flip-flop is clocked by Clk, so all Count bits change on the same edge with no ripple skew. Provides enable, synchronous clear, parallel load, a terminal-count flag, a one-cycle carry pulse for cascading, and a sticky overflow flag. Sits wherever the design needs a glitch-free up count, e.g. event tallies, prescalers and chained counter stages.

## Interface
- WIDTH, 3, counter width in bits; minimum 1.
- MODULUS, 8, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.

- Clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- Count  output  WIDTH  current count, registered.
- tc  output  1  terminal count: combinational, high when Count == MODULUS-1.
- carry  output  1  registered one-cycle pulse on wrap; drives en of the next stage.
- ovf  output  1  sticky overflow flag, registered.

## Operation
- Reset: while rst is high, Count = 0, carry = 0 and ovf = 0 immediately, independent of Clk. No other input has effect while rst is high.
- Per-edge priority is rst > clr > load > en. Exactly one action is taken per edge:
  - clr=1: Count <= 0, carry <= 0, ovf <= 0.
  - load=1: Count <= load_val, carry <= 0, ovf unchanged. If load_val >= MODULUS, Count <= MODULUS-1 (clamped).
  - en=1 and Count < MODULUS-1: Count <= Count+1, carry <= 0.
  - en=1 and Count == MODULUS-1: Count <= 0, carry <= 1, ovf <= 1 (wrap).
  - Otherwise: Count holds, carry <= 0.
- carry is never high on two consecutive edges unless en stays high and MODULUS == ... every edge wraps. That case is impossible, because MODULUS >= 2.
- Arithmetic: the increment is computed at WIDTH+1 bits and compared against MODULUS-1 before truncation. Count never holds a value >= MODULUS.
- Cascading: connect stage k carry to stage k+1 en, with a common Clk. The next stage advances one cycle after the wrap edge. This fixed one-cycle skew per stage is accepted.

## Timing
- Count, carry and ovf change only on a rising Clk edge or on a rising rst.
- Latency: an input sampled on edge n is reflected on Count after edge n. carry is high for exactly the cycle following the wrap edge.
- tc is combinational from Count. It is valid one settling time after edge n and has no dependency on en.
- Boundary cases:
  - load and en both high in the same cycle: load wins and no increment occurs.
  - clr and load both high: clr wins.
  - Loading MODULUS-1 gives tc=1 next cycle, and the following enabled edge wraps.
  - rst asserted mid-count: all outputs go to 0 immediately. Counting resumes from 0 on the first edge after rst falls, if en=1.
  - rst deassertion must meet recovery/removal timing relative to Clk. A synchronizer is the integrator's responsibility.

## Configuration
- UP_SATURATE_EN undefined (default): wrap behaviour as above.
- UP_SATURATE_EN defined: with en=1 at Count == MODULUS-1, Count holds at MODULUS-1, carry stays 0, and ovf <= 1. Only clr, load or rst leaves saturation. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with Count=5 -> Count=0, carry=0, ovf=0 before the next edge. Release rst with en=1 -> Count reads 1, 2, 3 on successive edges.
- Full wrap (WIDTH=3, MODULUS=8, en=1): Count goes 0..7, then 0. tc=1 only while Count=7. carry=1 for exactly one cycle after 7->0. ovf=1 from then on.
- Non-power-of-two (WIDTH=4, MODULUS=10): Count goes 0..9, then 0. Load load_val=12 -> Count=9 and tc=1.
- Priority: clr=load=en=1 with Count=4 -> Count=0. Then load=en=1 with load_val=6 -> Count=6, not 7.
- Hold: en=0 for 5 edges at Count=3 -> Count stays 3, carry stays 0.
- UP_SATURATE_EN defined, MODULUS=8, en=1 from 0: Count stops at 7 and remains 7 for 3 further edges. carry is never 1. ovf=1. clr -> Count=0 and ovf=0.

Source files
------------

// File: rtl/sync_up_counter.sv
// sync_up_counter: synchronous modulo-MODULUS up counter with enable,
// synchronous clear, clamped parallel load, combinational terminal count,
// a one-cycle registered carry pulse for cascading and a sticky overflow flag.
// Build option: define UP_SATURATE_EN to make the counter stop at MODULUS-1
// instead of wrapping (carry then never pulses; ovf still sets).
module sync_up_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] Count,
   output logic             tc,
   output logic             carry,
   output logic             ovf
);

   // Last legal count, held one bit wider so comparisons never truncate.
   localparam logic [WIDTH:0]   LAST_C = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] LAST_W = LAST_C[WIDTH-1:0];

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             carry_q;
   logic             carry_d;
   logic             ovf_q;
   logic             ovf_d;
   logic [WIDTH:0]   inc_s;
   logic             wrap_s;
   logic             load_big_s;

   // Next-state: clr beats load beats en; exactly one action per edge.
   always_comb begin
      count_d    = count_q;
      carry_d    = 1'b0;
      ovf_d      = ovf_q;
      inc_s      = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
      // Increment overshoots the last legal value only when sitting at it.
      wrap_s     = (inc_s > LAST_C);
      load_big_s = ({1'b0, load_val} > LAST_C);
      if (clr) begin
         count_d = {WIDTH{1'b0}};
         ovf_d   = 1'b0;
      end else if (load) begin
         // Out-of-range load values clamp so Count never leaves 0..MODULUS-1.
         if (load_big_s) begin
            count_d = LAST_W;
         end else begin
            count_d = load_val;
         end
      end else if (en) begin
         if (wrap_s) begin
`ifdef UP_SATURATE_EN
            count_d = count_q;
            carry_d = 1'b0;
            ovf_d   = 1'b1;
`else
            count_d = {WIDTH{1'b0}};
            carry_d = 1'b1;
            ovf_d   = 1'b1;
`endif
         end else begin
            count_d = inc_s[WIDTH-1:0];
         end
      end else begin
         count_d = count_q;
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         count_q <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Count = count_q;
   assign carry = carry_q;
   assign ovf   = ovf_q;
   // Terminal count decodes straight from the register, independent of en.
   assign tc    = ({1'b0, count_q} == LAST_C);

endmodule
